// File: rtl/avl_ram_slave.sv
// Avalon-MM RAM responder: programmable wait states, fixed-latency pipelined reads.
// Optional out-of-range address checking is enabled with `define AVL_RAM_RANGE_CHK_EN.
module avl_ram_slave #(
  parameter int          ADDR_W       = 12,
  parameter int          READ_LATENCY = 2,
  parameter int          WAIT_CYCLES  = 0,
  parameter logic [31:0] OOR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] avl_address,
  input  logic [3:0]  avl_byte_en,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic [31:0] avl_write_data,
  output logic        avl_waitrequest,
  output logic [31:0] avl_read_data,
  output logic        avl_read_data_valid,
  output logic        avl_err
);
  localparam int         DEPTH  = 2**ADDR_W;
  localparam logic [2:0] WAIT_N = 3'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                         state, state_nxt;
  logic [2:0]                     cnt, cnt_nxt;
  logic                           req, acc, rd_acc, wr_acc, oor;
  logic [ADDR_W-1:0]              idx;
  logic [31:0]                    mem [DEPTH];
  logic [READ_LATENCY:1]          vld_pipe;
  logic [READ_LATENCY:1][31:0]    dat_pipe;

  assign req    = avl_read | avl_write;
  assign acc    = req & ~avl_waitrequest;
  assign idx    = avl_address[ADDR_W+1:2];
  // Read wins when both strobes are set; the write is dropped.
  assign rd_acc = acc & avl_read;
  assign wr_acc = acc & avl_write & ~avl_read & ~oor;

`ifdef AVL_RAM_RANGE_CHK_EN
  logic unused_addr;
  assign oor         = |avl_address[31:ADDR_W+2];
  assign avl_err     = acc & oor;
  assign unused_addr = ^avl_address[1:0];
`else
  logic unused_addr;
  assign oor         = 1'b0;
  assign avl_err     = 1'b0;
  assign unused_addr = ^{avl_address[31:ADDR_W+2], avl_address[1:0]};
`endif

  // Wait-state FSM; waitrequest is combinational from the live request.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    avl_waitrequest = 1'b0;
    if (!rest) begin
      avl_waitrequest = 1'b1;
    end else if (!req) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (WAIT_CYCLES != 0) begin
      case (state)
        S_IDLE: begin
          avl_waitrequest = 1'b1;
          state_nxt       = S_WAIT;
          cnt_nxt         = 3'd1;
        end
        S_WAIT: begin
          if (cnt != WAIT_N) begin
            avl_waitrequest = 1'b1;
            cnt_nxt         = cnt + 3'd1;
          end else begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // RAM array has no reset; contents survive rest.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++)
        if (avl_byte_en[b]) mem[idx][8*b +: 8] <= avl_write_data[8*b +: 8];
    end
  end

  // Data stages only advance behind a valid, so the output holds between responses.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= oor ? OOR_DATA : mem[idx];
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign avl_read_data       = dat_pipe[READ_LATENCY];
  assign avl_read_data_valid = vld_pipe[READ_LATENCY];

endmodule

// File: tb/tb_avl_ram_slave.sv
// Bench for avl_ram_slave: three instances (W0/L2, W3/L2, W0/L4), array model + response scoreboard.
module tb_avl_ram_slave;
  localparam int N      = 3;
  localparam int ADDR_W = 12;
  localparam logic [31:0] OOR = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rest [N];
  logic [31:0] addr [N];
  logic [3:0]  be   [N];
  logic        rd   [N];
  logic        wr   [N];
  logic [31:0] wdat [N];
  logic        wreq [N];
  logic [31:0] rdat [N];
  logic        vld  [N];
  logic        err  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    avl_ram_slave #(
      .ADDR_W(ADDR_W), .READ_LATENCY(g == 2 ? 4 : 2),
      .WAIT_CYCLES(g == 1 ? 3 : 0), .OOR_DATA(OOR)
    ) u_dut (
      .clk(clk), .rest(rest[g]), .avl_address(addr[g]), .avl_byte_en(be[g]),
      .avl_read(rd[g]), .avl_write(wr[g]), .avl_write_data(wdat[g]),
      .avl_waitrequest(wreq[g]), .avl_read_data(rdat[g]),
      .avl_read_data_valid(vld[g]), .avl_err(err[g])
    );
  end

  int          nchk = 0;
  int          npass = 0;
  logic [31:0] mdl [N][4096];
  exp_t        exp_q [N][$];
  int          last_acc [N];

  function automatic int wc(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic int lat(input int k);
    return (k == 2) ? 4 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    int   waits = 0;
    bit   tmo = 1'b0;
    bit   oor;
    logic [11:0] i;
    rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wdat[k] = d;
    forever begin
      @(negedge clk);
      if (!wreq[k]) break;
      waits++;
      if (waits > 20) begin tmo = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (tmo) begin
      chk($sformatf("dut%0d accept timeout", k), 32'(waits), 32'(wc(k)));
      rd[k] = 1'b0; wr[k] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    chk($sformatf("dut%0d wait cycles", k), 32'(waits), 32'(wc(k)));
`ifdef AVL_RAM_RANGE_CHK_EN
    oor = |a[31:ADDR_W+2];
`else
    oor = 1'b0;
`endif
    chk($sformatf("dut%0d err", k), {31'b0, err[k]}, {31'b0, oor});
    i = a[ADDR_W+1:2];
    if (r) exp_q[k].push_back('{oor ? OOR : mdl[k][i], 32'(cyc + lat(k))});
    else if (w && !oor)
      for (int j = 0; j < 4; j++) if (b[j]) mdl[k][i][8*j +: 8] = d[8*j +: 8];
    last_acc[k] = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k, input int n);
    rd[k] = 1'b0; wr[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (vld[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("dut%0d spurious valid", k), {31'b0, vld[k]}, 32'd0);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("dut%0d read data", k), rdat[k], e.d);
            chk($sformatf("dut%0d valid cycle", k), 32'(cyc), e.due);
          end
        end
      end
    end
  endtask

  initial begin
    int t0;
    for (int k = 0; k < N; k++) begin
      rest[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
      addr[k] = '0; be[k] = '0; wdat[k] = '0; last_acc[k] = 0;
    end
    fork monitor(); join_none

    // Reset state
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        chk($sformatf("dut%0d rst waitreq", k), {31'b0, wreq[k]}, 32'd1);
        chk($sformatf("dut%0d rst valid", k), {31'b0, vld[k]}, 32'd0);
        chk($sformatf("dut%0d rst data", k), rdat[k], 32'd0);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) rest[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++)
      chk($sformatf("dut%0d idle waitreq", k), {31'b0, wreq[k]}, 32'd0);
    @(posedge clk); #1;

    // Fill the working window of each instance
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 64; i++) access(k, 0, 1, 32'(i * 4), 4'hF, $urandom);
      idle(k, 1);
    end

    // Full write then read-after-write, then a single-byte write
    access(0, 0, 1, 32'h10, 4'hF, 32'h1234_5678);
    access(0, 1, 0, 32'h10, 4'h0, 32'h0);
    access(0, 0, 1, 32'h10, 4'b0010, 32'hAAAA_BBCC);
    access(0, 1, 0, 32'h10, 4'h0, 32'h0);
    idle(0, 4);

    // Wait states: back-to-back reads accepted WAIT_CYCLES+1 apart
    access(1, 1, 0, 32'h8, 4'h0, 32'h0);
    t0 = last_acc[1];
    access(1, 1, 0, 32'hC, 4'h0, 32'h0);
    chk("dut1 b2b spacing", 32'(last_acc[1] - t0), 32'd4);
    idle(1, 3);

    // Drop a write mid-wait: nothing happens, next access waits the full count
    rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h14; be[1] = 4'hF; wdat[1] = ~mdl[1][5];
    @(negedge clk); chk("dut1 drop waitreq0", {31'b0, wreq[1]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("dut1 drop waitreq1", {31'b0, wreq[1]}, 32'd1);
    @(posedge clk); #1;
    idle(1, 1);
    access(1, 1, 0, 32'h14, 4'h0, 32'h0);
    idle(1, 3);

    // Latency 4: four reads in consecutive cycles
    for (int i = 0; i < 4; i++) access(2, 1, 0, 32'(i * 4), 4'h0, 32'h0);
    idle(2, 6);

    // Reset with two reads in flight
    access(2, 1, 0, 32'h20, 4'h0, 32'h0);
    access(2, 1, 0, 32'h24, 4'h0, 32'h0);
    rest[2] = 1'b0; rd[2] = 1'b0;
    exp_q[2].delete();
    repeat (3) begin
      @(negedge clk);
      chk("dut2 midrst waitreq", {31'b0, wreq[2]}, 32'd1);
      chk("dut2 midrst valid", {31'b0, vld[2]}, 32'd0);
      chk("dut2 midrst data", rdat[2], 32'd0);
    end
    @(posedge clk); #1;
    rest[2] = 1'b1;
    idle(2, 8);
    access(2, 1, 0, 32'h20, 4'h0, 32'h0);
    access(2, 1, 0, 32'h24, 4'h0, 32'h0);
    idle(2, 6);

    // Address beyond the RAM: error/OOR data with the check, aliasing without
    access(0, 1, 0, 32'h0000_4000, 4'h0, 32'h0);
    access(0, 0, 1, 32'h0000_4000, 4'hF, 32'h5555_AAAA);
    access(0, 1, 0, 32'h0, 4'h0, 32'h0);
    idle(0, 4);

    // Randomized mix: reads, byte-masked writes, read+write, random gaps
    for (int k = 0; k < N; k++) begin
      repeat (60) begin
        int op;
        logic [31:0] a;
        op = $urandom_range(0, 9);
        a  = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
        if (op < 5)      access(k, 1, 0, a, 4'($urandom), $urandom);
        else if (op < 9) access(k, 0, 1, a, 4'($urandom), $urandom);
        else             access(k, 1, 1, a, 4'hF, $urandom);
        if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 2));
      end
      idle(k, 6);
    end

    for (int k = 0; k < N; k++)
      chk($sformatf("dut%0d pending responses", k), 32'(exp_q[k].size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
